// File: rtl/color_bbox_tracker_if.sv
// Pixel-stream / tracking-result bundle for color_bbox_tracker.
//   i_pix_valid, i_x, i_y, i_rgb ([0]=R,[1]=G,[2]=B), i_frame_end : pixel stream
//   o_left/o_right/o_up/o_down ([0]=x,[1]=y), o_count, o_predict_valid : results
// master = pixel source / result consumer, slave = the tracker.
interface color_bbox_tracker_if;
  logic        i_pix_valid;
  logic [10:0] i_x;
  logic [10:0] i_y;
  logic [7:0]  i_rgb [2:0];
  logic        i_frame_end;
  logic [10:0] o_left  [1:0];
  logic [10:0] o_right [1:0];
  logic [10:0] o_up    [1:0];
  logic [10:0] o_down  [1:0];
  logic [20:0] o_count;
  logic        o_predict_valid;

  modport master (
    output i_pix_valid, i_x, i_y, i_rgb, i_frame_end,
    input  o_left, o_right, o_up, o_down, o_count, o_predict_valid
  );

  modport slave (
    input  i_pix_valid, i_x, i_y, i_rgb, i_frame_end,
    output o_left, o_right, o_up, o_down, o_count, o_predict_valid
  );
endinterface

// File: rtl/color_bbox_tracker.sv
// Colour-window bounding-point tracker.
// Finds per frame the leftmost/rightmost/topmost/bottommost pixel whose colour
// lies in the threshold window, and publishes them with a one-cycle
// o_predict_valid pulse two cycles after i_frame_end.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   bus    color_bbox_tracker_if.slave (pixel stream in, extreme points out)
module color_bbox_tracker #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned R_MAX      = 100,
  parameter int unsigned G_MIN      = 150,
  parameter int unsigned B_MAX      = 100,
  parameter int unsigned MIN_PIXELS = 16,
  parameter logic [10:0] NOT_FOUND  = 11'd2023
) (
  input logic                  i_clk,
  input logic                  i_rst,
  color_bbox_tracker_if.slave  bus
);

  typedef enum logic {S_ACCUM, S_PUBLISH} state_t;

  typedef struct packed {
    logic [20:0] cnt;
    logic [10:0] min_x, max_x, min_y, max_y;
    logic [10:0] lx, ly, rx, ry, ux, uy, dx, dy;
  } acc_t;

  localparam acc_t ACC_INIT = '{
    cnt: '0, min_x: '1, max_x: '0, min_y: '1, max_y: '0,
    lx: NOT_FOUND, ly: NOT_FOUND, rx: NOT_FOUND, ry: NOT_FOUND,
    ux: NOT_FOUND, uy: NOT_FOUND, dx: NOT_FOUND, dy: NOT_FOUND
  };

  state_t      state, state_nxt;
  acc_t        acc, acc_base, acc_upd;
  logic        match0;
  logic        m1, e1;
  logic [10:0] x1, y1;
  logic        found;

  // Stage 1: classify the incoming pixel
  always_comb begin
    match0 = bus.i_pix_valid
          && (32'(bus.i_x) < H_ACTIVE) && (32'(bus.i_y) < V_ACTIVE)
          && (32'(bus.i_rgb[0]) <= R_MAX)
          && (32'(bus.i_rgb[1]) >= G_MIN)
          && (32'(bus.i_rgb[2]) <= B_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m1 <= 1'b0;
      e1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
    end else begin
      m1 <= match0;
      e1 <= bus.i_frame_end;
      x1 <= bus.i_x;
      y1 <= bus.i_y;
    end
  end

  // Next state, publish strobe and accumulator update.
  // In S_PUBLISH the update starts from the initial values, so clearing and the
  // pixel arriving in that cycle merge; a frame end there publishes again.
  always_comb begin
    state_nxt           = S_ACCUM;
    bus.o_predict_valid = 1'b0;
    acc_base            = acc;
    case (state)
      S_ACCUM: begin
        if (e1) state_nxt = S_PUBLISH;
      end
      S_PUBLISH: begin
        bus.o_predict_valid = 1'b1;
        acc_base            = ACC_INIT;
        if (e1) state_nxt = S_PUBLISH;
      end
      default: state_nxt = S_ACCUM;
    endcase

    acc_upd = acc_base;
    if (m1) begin
      if (acc_base.cnt != '1) acc_upd.cnt = acc_base.cnt + 21'd1;
      if (x1 < acc_base.min_x) begin
        acc_upd.min_x = x1;
        acc_upd.lx    = x1;
        acc_upd.ly    = y1;
      end
      if (x1 > acc_base.max_x) begin
        acc_upd.max_x = x1;
        acc_upd.rx    = x1;
        acc_upd.ry    = y1;
      end
      if (y1 < acc_base.min_y) begin
        acc_upd.min_y = y1;
        acc_upd.ux    = x1;
        acc_upd.uy    = y1;
      end
      if (y1 > acc_base.max_y) begin
        acc_upd.max_y = y1;
        acc_upd.dx    = x1;
        acc_upd.dy    = y1;
      end
    end
    found = 32'(acc_upd.cnt) >= MIN_PIXELS;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_ACCUM;
      acc   <= ACC_INIT;
    end else begin
      state <= state_nxt;
      acc   <= acc_upd;
    end
  end

  // Output registers double as the frame snapshot: loaded on the cycle the
  // frame-end pixel is accumulated, so they are valid during S_PUBLISH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_left[0]  <= NOT_FOUND;
      bus.o_left[1]  <= NOT_FOUND;
      bus.o_right[0] <= NOT_FOUND;
      bus.o_right[1] <= NOT_FOUND;
      bus.o_up[0]    <= NOT_FOUND;
      bus.o_up[1]    <= NOT_FOUND;
      bus.o_down[0]  <= NOT_FOUND;
      bus.o_down[1]  <= NOT_FOUND;
      bus.o_count    <= '0;
    end else if (e1) begin
      bus.o_left[0]  <= found ? acc_upd.lx : NOT_FOUND;
      bus.o_left[1]  <= found ? acc_upd.ly : NOT_FOUND;
      bus.o_right[0] <= found ? acc_upd.rx : NOT_FOUND;
      bus.o_right[1] <= found ? acc_upd.ry : NOT_FOUND;
      bus.o_up[0]    <= found ? acc_upd.ux : NOT_FOUND;
      bus.o_up[1]    <= found ? acc_upd.uy : NOT_FOUND;
      bus.o_down[0]  <= found ? acc_upd.dx : NOT_FOUND;
      bus.o_down[1]  <= found ? acc_upd.dy : NOT_FOUND;
      bus.o_count    <= acc_upd.cnt;
    end
  end

endmodule

// File: doc/color_bbox_tracker.md
Name: color_bbox_tracker

Overview:
- Consumes the VGA/camera pixel stream (coordinate plus RGB) and finds the pixels whose colour lies inside a fixed threshold window.
- For each frame it reports four extreme points: leftmost, rightmost, topmost and bottommost matching pixel. Each point is an (x,y) pair.
- It publishes these points with a one-cycle predict_valid pulse. This is the producer side of the left/right/up/down/predict_valid interface that the game logic consumes.
- When too few pixels match, all points carry the not-found sentinel 2023.

Parameters:
- H_ACTIVE, 640, pixels with x >= H_ACTIVE are ignored.
- V_ACTIVE, 480, pixels with y >= V_ACTIVE are ignored.
- R_MAX, 100, a pixel matches only if R <= R_MAX.
- G_MIN, 150, a pixel matches only if G >= G_MIN.
- B_MAX, 100, a pixel matches only if B <= B_MAX.
- MIN_PIXELS, 16, minimum match count needed to report a valid box.
- NOT_FOUND, 11'd2023, sentinel coordinate.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_pix_valid  in  1  current pixel is valid
- i_x  in  11  pixel x coordinate
- i_y  in  11  pixel y coordinate
- i_rgb  in  3x8  unpacked [2:0]; [0]=R, [1]=G, [2]=B
- i_frame_end  in  1  one-cycle pulse marking the last pixel of a frame
- o_left  out  2x11  [0]=x, [1]=y of the leftmost match
- o_right  out  2x11  [0]=x, [1]=y of the rightmost match
- o_up  out  2x11  [0]=x, [1]=y of the topmost match
- o_down  out  2x11  [0]=x, [1]=y of the bottommost match
- o_count  out  21  number of matches in the last published frame, saturating
- o_predict_valid  out  1  one-cycle pulse when new outputs are published

Behaviour:
- Reset (async, i_rst=1):
  - All o_left/o_right/o_up/o_down elements = NOT_FOUND.
  - o_count = 0, o_predict_valid = 0.
  - Accumulators cleared; state = S_ACCUM.
- Stage 1 (registered): m1 = i_pix_valid && i_x<H_ACTIVE && i_y<V_ACTIVE && colour in window.
  - Comparisons are unsigned and inclusive.
  - x1, y1 and e1 (i_frame_end) are registered alongside m1.
- Stage 2, accumulator update when m1=1:
  - count = min(count+1, 2^21-1).
  - left updates when x1 < min_x (strict). The first pixel in raster order wins ties. Same rule for up with y1 < min_y.
  - right updates when x1 > max_x (strict). down updates when y1 > max_y (strict). The first pixel wins ties.
  - On update, both coordinates of that extreme point are captured.
  - Accumulator initial values: min_x = min_y = 2047, max_x = max_y = 0, count = 0.
- States:
  - S_ACCUM: accumulate. When e1=1, the stage-2 update for that same pixel is applied first, the result is latched into the output snapshot, and the FSM goes to S_PUBLISH.
  - S_PUBLISH (exactly one cycle):
    - o_predict_valid = 1.
    - If snapshot count >= MIN_PIXELS, outputs take the snapshot points; otherwise all eight coordinates = NOT_FOUND.
    - o_count = snapshot count in either case.
    - Accumulators are reset to their initial values; return to S_ACCUM.
- Latency: the i_frame_end pulse at cycle T gives o_predict_valid at cycle T+2.
- Outputs hold their values between publishes.
- A pixel arriving during S_PUBLISH is accumulated into the new frame. Clearing and that pixel's update merge, so the pixel is not lost.
- Back-to-back i_frame_end pulses (two frames of one pixel each) are legal. They yield two publishes, 1 cycle apart.
- i_frame_end with i_pix_valid=0 still publishes. The frame's last pixel is simply absent.
- Reset mid-frame discards the partial frame. The first publish after reset covers only the pixels seen after reset.
- No input stall: the block accepts one pixel per cycle continuously.

Test Plan:
1. Reset -> all coords 2023, o_count 0, o_predict_valid 0. Then a 640x480 frame with a green (R=0,G=255,B=0) 10x10 square at x 100..109, y 50..59, plus i_frame_end on the last pixel. Two cycles later, one-cycle o_predict_valid with:
   - left = (100,50), right = (109,50), up = (100,50), down = (100,59), o_count = 100.
2. Frame with only 15 matching pixels -> o_predict_valid pulses, all eight coords = 2023, o_count = 15. Same frame with 16 pixels -> real coordinates.
3. Matches placed at x=700 and y=500 (out of active area), plus colour-boundary pixels:
   - R=100,G=150,B=100 is counted.
   - R=101 and G=149 are not counted.
4. i_frame_end coincident with a matching pixel at (639,479) -> right = (639,479), down = (639,479). The next frame's pixel at (5,5), presented in the S_PUBLISH cycle, appears as left = (5,5) in the following publish.
5. Assert i_rst mid-frame after 40 matches -> outputs go to 2023 immediately with no publish pulse. The subsequent frame reports only post-reset matches.
6. Back-to-back i_frame_end on consecutive cycles with matches at (3,4) then (8,9) -> two pulses one cycle apart, reporting (3,4) and then (8,9) as all four extremes (MIN_PIXELS overridden to 1).
